// File: rtl/score_disp_pkg.sv
// Shared types and segment table for the score display.
// Imported by score_display_ctrl and bin2bcd_seq.
package score_disp_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_STEADY = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_FLASH  = 2'b11
    } disp_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_UPDATE
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111
    };

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        if (d <= 4'd9) return SEG_DIGIT[d];
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one binary bit per cycle.
// done is high during the final step; bcd is valid the cycle after.
module bin2bcd_seq
    import score_disp_pkg::*;
#(
    parameter int SCORE_W     = 7,
    parameter int CONV_DIGITS = (SCORE_W + 2) / 3
) (
    input  logic                     clk,
    input  logic                     nRst,
    input  logic                     start,
    input  logic [SCORE_W-1:0]       bin,
    output logic                     done,
    output logic [4*CONV_DIGITS-1:0] bcd
);

    localparam int CW    = 4 * CONV_DIGITS;
    localparam int CNT_W = $clog2(SCORE_W + 1);

    logic [SCORE_W-1:0] sh;
    logic [CW-1:0]      acc;
    logic [CW-1:0]      adj;
    logic [CNT_W-1:0]   cnt;

    always_comb begin
        adj = acc;
        for (int k = 0; k < CONV_DIGITS; k++) begin
            if (acc[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sh  <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (start) begin
            sh  <= bin;
            acc <= '0;
            cnt <= CNT_W'(SCORE_W);
        end else if (cnt != '0) begin
            acc <= {adj[CW-2:0], sh[SCORE_W-1]};
            sh  <= sh << 1;
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == CNT_W'(1));
    assign bcd  = acc;

endmodule

// File: rtl/score_display_ctrl.sv
// Multi-digit score display: sequential BCD conversion, saturation,
// leading-zero blanking and steady/blink/flash segment gating.
module score_display_ctrl
    import score_disp_pkg::*;
#(
    parameter int SCORE_W      = 7,
    parameter int NUM_DIGITS   = 3,
    parameter int BLINK_DIV    = 100,
    parameter int FLASH_HALVES = 6
) (
    input  logic                    clk,
    input  logic                    nRst,
    input  logic [SCORE_W-1:0]      score,
    input  logic                    score_valid,
    input  logic [1:0]              mode,
    input  logic                    lz_blank,
    output logic                    busy,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] seg
);

    localparam int CONV_DIGITS = (SCORE_W + 2) / 3;
    localparam int MAXD = (CONV_DIGITS > NUM_DIGITS) ?
                          CONV_DIGITS : NUM_DIGITS;
    localparam int BW      = 4 * NUM_DIGITS;
    localparam int CW      = 4 * CONV_DIGITS;
    localparam int PW      = 4 * MAXD;
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam int FL_W    = $clog2(FLASH_HALVES + 1);

    conv_state_t state, state_n;
    disp_mode_t  mode_e;

    logic               pend_full;
    logic [SCORE_W-1:0] pend_score;
    logic               start;
    logic               consume;
    logic [SCORE_W-1:0] start_bin;
    logic               conv_done;
    logic [CW-1:0]      conv_bcd;
    logic [PW-1:0]      conv_pad;

    logic [BW-1:0]            bcd_q, upd_bcd;
    logic                     ovf_q, upd_ovf;
    logic [7*NUM_DIGITS-1:0]  seg_q, seg_n;
    logic [BLINK_W-1:0]       blink_cnt;
    logic                     phase_on;
    logic [FL_W-1:0]          flash_cnt;
    logic                     wrap;
    logic                     flash_load;
    logic                     seen;
    logic                     en;

    assign mode_e = disp_mode_t'(mode);

    bin2bcd_seq #(
        .SCORE_W     (SCORE_W),
        .CONV_DIGITS (CONV_DIGITS)
    ) u_conv (
        .clk   (clk),
        .nRst  (nRst),
        .start (start),
        .bin   (start_bin),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state <= ST_IDLE;
        else       state <= state_n;
    end

    // A slot filled during UPDATE is picked up from IDLE next cycle
    always_comb begin
        state_n   = state;
        start     = 1'b0;
        consume   = 1'b0;
        start_bin = score;
        unique case (state)
            ST_IDLE: begin
                if (score_valid) begin
                    start   = 1'b1;
                    consume = pend_full;
                    state_n = ST_CONVERT;
                end else if (pend_full) begin
                    start     = 1'b1;
                    consume   = 1'b1;
                    start_bin = pend_score;
                    state_n   = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (conv_done) state_n = ST_UPDATE;
            end
            ST_UPDATE: begin
                if (pend_full) begin
                    start     = 1'b1;
                    consume   = 1'b1;
                    start_bin = pend_score;
                    state_n   = ST_CONVERT;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pend_full  <= 1'b0;
            pend_score <= '0;
        end else if (score_valid && state != ST_IDLE) begin
            pend_full  <= 1'b1;
            pend_score <= score;
        end else if (consume) begin
            pend_full  <= 1'b0;
        end
    end

    assign conv_pad = PW'(conv_bcd);

    always_comb begin
        upd_ovf = 1'b0;
        for (int k = NUM_DIGITS; k < MAXD; k++) begin
            if (conv_pad[4*k +: 4] != 4'd0) upd_ovf = 1'b1;
        end
        upd_bcd = upd_ovf ? {NUM_DIGITS{4'h9}} : conv_pad[BW-1:0];
    end

    assign flash_load = (state == ST_UPDATE) && (mode_e == MODE_FLASH) &&
                        ((upd_bcd != bcd_q) || (upd_ovf != ovf_q));

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            bcd_q <= '0;
            ovf_q <= 1'b0;
        end else if (state == ST_UPDATE) begin
            bcd_q <= upd_bcd;
            ovf_q <= upd_ovf;
        end
    end

    assign wrap = (blink_cnt == BLINK_W'(BLINK_DIV - 1));

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
            flash_cnt <= '0;
        end else if (flash_load) begin
            blink_cnt <= '0;
            phase_on  <= 1'b0;
            flash_cnt <= FL_W'(FLASH_HALVES);
        end else begin
            blink_cnt <= wrap ? '0 : blink_cnt + 1'b1;
            if (wrap) phase_on <= ~phase_on;
            if (mode_e != MODE_FLASH)
                flash_cnt <= '0;
            else if (wrap && flash_cnt != '0)
                flash_cnt <= flash_cnt - 1'b1;
        end
    end

    always_comb begin
        seen  = 1'b0;
        seg_n = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (bcd_q[4*k +: 4] != 4'd0) seen = 1'b1;
            if (seen || k == 0 || !lz_blank || ovf_q)
                seg_n[7*k +: 7] = seg_of(bcd_q[4*k +: 4]);
        end
        en = 1'b0;
        unique case (mode_e)
            MODE_OFF:    en = 1'b0;
            MODE_STEADY: en = 1'b1;
            MODE_BLINK:  en = phase_on;
            MODE_FLASH:  en = (flash_cnt != '0) ? phase_on : 1'b1;
            default:     en = 1'b0;
        endcase
        if (!en) seg_n = '0;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) seg_q <= '0;
        else       seg_q <= seg_n;
    end

    assign busy     = (state != ST_IDLE) || pend_full;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;
    assign seg      = seg_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl with an expected-result queue.
// A 3-digit and a 2-digit instance share the same stimulus.
module tb_score_display_ctrl;

    logic        clk = 1'b0;
    logic        nRst;
    logic [6:0]  score;
    logic        score_valid;
    logic [1:0]  mode;
    logic        lz_blank;

    logic        busy, busy2;
    logic [11:0] bcd;
    logic [7:0]  bcd2;
    logic        overflow, overflow2;
    logic [20:0] seg;
    logic [13:0] seg2;

    int checks = 0;
    int failures = 0;

    logic [21:0] exp_q[$];
    logic [6:0]  segt [10];

    always #5 clk = ~clk;

    score_display_ctrl #(
        .SCORE_W(7), .NUM_DIGITS(3),
        .BLINK_DIV(4), .FLASH_HALVES(4)
    ) dut (
        .clk(clk), .nRst(nRst),
        .score(score), .score_valid(score_valid),
        .mode(mode), .lz_blank(lz_blank),
        .busy(busy), .bcd(bcd),
        .overflow(overflow), .seg(seg)
    );

    score_display_ctrl #(
        .SCORE_W(7), .NUM_DIGITS(2),
        .BLINK_DIV(4), .FLASH_HALVES(4)
    ) dut2 (
        .clk(clk), .nRst(nRst),
        .score(score), .score_valid(score_valid),
        .mode(mode), .lz_blank(lz_blank),
        .busy(busy2), .bcd(bcd2),
        .overflow(overflow2), .seg(seg2)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h",
                     tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {ovf2, bcd2, ovf1, bcd1} from plain decimal arithmetic
    function automatic logic [21:0] model(input int v);
        logic [3:0] o, t, h;
        logic [21:0] r;
        o = 4'((v % 10));
        t = 4'(((v / 10) % 10));
        h = 4'(((v / 100) % 10));
        r[11:0]  = {h, t, o};
        r[12]    = (v > 999);
        r[21]    = (v > 99);
        r[20:13] = (v > 99) ? 8'h99 : {t, o};
        return r;
    endfunction

    function automatic logic [20:0] seg3(input logic [11:0] b,
                                         input logic lz);
        logic [20:0] s;
        logic nz;
        s  = '0;
        nz = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            if (b[4*k +: 4] != 0) nz = 1'b1;
            if (nz || k == 0 || !lz)
                s[7*k +: 7] = segt[b[4*k +: 4]];
        end
        return s;
    endfunction

    task automatic push_exp(input int v);
        exp_q.push_back(model(v));
    endtask

    task automatic pop_check(input string tag);
        logic [21:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_qempty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_bcd"}, {19'd0, overflow, bcd},
                  {19'd0, e[12:0]});
            check({tag, "_bcd2"}, {23'd0, overflow2, bcd2},
                  {23'd0, e[21:13]});
        end
    endtask

    task automatic send(input int v);
        score       = 7'(v);
        score_valid = 1'b1;
        tick();
        score_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check("idle_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int n, on_cnt, bad;
        logic [6:0] s [16];
        logic [6:0] p;
        segt = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                 7'b1111111, 7'b1101111};

        // reset
        nRst = 1'b0;
        score = '0;
        score_valid = 1'b0;
        mode = 2'b01;
        lz_blank = 1'b1;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_seg", 32'(seg), 32'd0);
        nRst = 1'b1;
        tick();
        check("rst_seg0", 32'(seg), {11'd0, 21'h00003F});

        // 123: latency and display
        send(123);
        push_exp(123);
        wait_idle(n);
        check("lat123", 32'(n), 32'd8);
        pop_check("v123");
        tick();
        check("seg123", 32'(seg), 32'(seg3(12'h123, 1'b1)));
        check("seg2_ovf", 32'(seg2), {18'd0, segt[9], segt[9]});

        // leading-zero blanking on and off
        send(5);
        push_exp(5);
        wait_idle(n);
        pop_check("v5");
        tick();
        check("seg5_lz", 32'(seg), 32'(seg3(12'h005, 1'b1)));
        lz_blank = 1'b0;
        tick();
        tick();
        check("seg5_nolz", 32'(seg), 32'(seg3(12'h005, 1'b0)));
        lz_blank = 1'b1;

        // saturation on the 2-digit instance
        send(127);
        push_exp(127);
        wait_idle(n);
        pop_check("v127");
        send(42);
        push_exp(42);
        wait_idle(n);
        pop_check("v42");

        // pending slot: latest wins
        send(45);
        push_exp(45);
        tick();
        tick();
        score = 7'd67;
        score_valid = 1'b1;
        tick();
        score_valid = 1'b0;
        tick();
        score = 7'd89;
        score_valid = 1'b1;
        tick();
        score_valid = 1'b0;
        push_exp(89);
        tick();
        tick();
        tick();
        pop_check("v45");
        check("busy_pend", 32'(busy), 32'd1);
        wait_idle(n);
        check("lat89", 32'(n), 32'd8);
        pop_check("v89");

        // request arriving in the UPDATE cycle
        send(10);
        push_exp(10);
        repeat (7) tick();
        score = 7'd20;
        score_valid = 1'b1;
        tick();
        score_valid = 1'b0;
        push_exp(20);
        pop_check("v10");
        check("busy_upd", 32'(busy), 32'd1);
        wait_idle(n);
        check("lat20", 32'(n), 32'd9);
        pop_check("v20");

        // blink mode
        send(5);
        push_exp(5);
        wait_idle(n);
        pop_check("v5b");
        mode = 2'b10;
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            s[i] = seg[6:0];
        end
        on_cnt = 0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (s[i] == segt[5]) on_cnt++;
            else if (s[i] != 7'd0) bad++;
        end
        check("blink_on", 32'(on_cnt), 32'd8);
        check("blink_vals", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 4; i < 16; i++) begin
            if (s[i] == s[i-4]) bad++;
        end
        check("blink_period", 32'(bad), 32'd0);
        mode = 2'b00;
        tick();
        tick();
        check("mode_off", 32'(seg), 32'd0);

        // flash on change
        mode = 2'b11;
        send(7);
        push_exp(7);
        wait_idle(n);
        pop_check("v7");
        repeat (30) tick();
        send(8);
        push_exp(8);
        repeat (8) tick();
        pop_check("v8");
        p = segt[8];
        for (int t = 9; t <= 32; t++) begin
            tick();
            if ((t >= 9 && t <= 12) || (t >= 17 && t <= 20))
                check($sformatf("flash_t%0d", t), 32'(seg[6:0]), 32'd0);
            else
                check($sformatf("flash_t%0d", t), 32'(seg[6:0]), 32'(p));
        end

        // equal value: no retrigger
        send(8);
        push_exp(8);
        repeat (8) tick();
        pop_check("v8r");
        bad = 0;
        for (int t = 9; t <= 24; t++) begin
            tick();
            if (seg[6:0] != p) bad++;
        end
        check("no_reflash", 32'(bad), 32'd0);

        // reset during conversion
        send(99);
        tick();
        tick();
        nRst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_bcd", 32'(bcd), 32'd0);
        check("arst_seg", 32'(seg), 32'd0);
        #2;
        nRst = 1'b1;
        repeat (12) tick();
        check("post_busy", 32'(busy), 32'd0);
        check("post_bcd", 32'({overflow, bcd}), 32'd0);
        check("post_seg", 32'(seg), 32'h00003F);
        check("q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
